// File: rtl/bundler_pkg.sv
// bundler_pkg: shared hypervector width and bundler FSM state encoding
package bundler_pkg;
    localparam int HV_DIM = 1024;
    typedef enum logic [1:0] {IDLE, ACCUM, THRESH, OUT} state_t;
endpackage

// File: rtl/bundler_bit_counter.sv
// bit_counter: CNT_W-bit counter with synchronous clear and saturating increment
//   clk, nrst : clock, async active-low reset
//   en        : hold everything when low
//   clr, inc  : clear has priority over increment
//   count     : current value, sticks at all-ones
module bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) count <= '0;
        else if (en) count <= clr ? '0 : (inc && count != '1) ? count + 1'b1 : count;
endmodule

// File: rtl/bundler.sv
// bundler: majority-style bundling of NUM_INPUTS bound hypervectors into one sample
//   clk, nrst        : clock, async active-low reset
//   en               : global enable, freezes all state when low
//   start_bundling   : begins a sample (IDLE only)
//   in_valid/in_ready, bound_hv   : input stream, accepted in ACCUM
//   out_valid/out_ready, sample_hv: thresholded result, held until handshake
//   busy             : not IDLE
module bundler
    import bundler_pkg::*;
#(
    parameter int DIM        = HV_DIM,
    parameter int NUM_INPUTS = 8,
    parameter int CNT_W      = 4,
    parameter int THRESHOLD  = 4
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           en,
    input  logic           start_bundling,
    input  logic           in_valid,
    input  logic [DIM-1:0] bound_hv,
    output logic           in_ready,
    input  logic           out_ready,
    output logic           out_valid,
    output logic [DIM-1:0] sample_hv,
    output logic           busy
);
    localparam int IN_W = $clog2(NUM_INPUTS + 1);
    localparam logic [IN_W-1:0] LAST = IN_W'(NUM_INPUTS - 1);
    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

    state_t state, next_state;
    logic [IN_W-1:0] in_cnt;
    logic [CNT_W-1:0] cnt [DIM];
    logic [DIM-1:0] hits;
    logic clr, accept;

    assign clr      = en && state == IDLE && start_bundling;
    assign accept   = en && state == ACCUM && in_valid;
    assign in_ready = en && state == ACCUM;
    assign busy     = state != IDLE;

    for (genvar i = 0; i < DIM; i++) begin : g_cnt
        bit_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk  (clk),
            .nrst (nrst),
            .en   (en),
            .clr  (clr),
            .inc  (accept && bound_hv[i]),
            .count(cnt[i])
        );
        assign hits[i] = cnt[i] >= THR;
    end

    always_comb begin
        next_state = state;
        if (en)
            case (state)
                IDLE:    next_state = start_bundling ? ACCUM : IDLE;
                ACCUM:   next_state = (in_valid && in_cnt == LAST) ? THRESH : ACCUM;
                THRESH:  next_state = OUT;
                OUT:     next_state = out_ready ? IDLE : OUT;
                default: next_state = IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            state     <= IDLE;
            in_cnt    <= '0;
            sample_hv <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            state     <= next_state;
            in_cnt    <= clr ? '0 : accept ? in_cnt + 1'b1 : in_cnt;
            sample_hv <= state == THRESH ? hits : sample_hv;
            out_valid <= state == THRESH ? 1'b1 : (state == OUT && out_ready) ? 1'b0 : out_valid;
        end
endmodule

// File: tb/tb_bundler.sv
// tb_bundler: table-driven and corner-case bench for bundler with a sample scoreboard
module tb_bundler;
    logic clk = 0, nrst = 0, en = 1;
    logic start = 0, in_valid = 0, out_ready = 1;
    logic [7:0] hv = '0;
    logic in_ready, out_valid, busy;
    logic [7:0] sample_hv;
    logic start_b = 0, in_valid_b = 0;
    logic [7:0] hv_b = '0;
    logic in_ready_b, out_valid_b, busy_b;
    logic [7:0] sample_hv_b;
    int checks = 0, failures = 0;
    logic [7:0] exp_q[$];

    typedef struct packed {
        logic [3:0][7:0] v;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[7];

    always #5 clk = ~clk;

    bundler #(.DIM(8), .NUM_INPUTS(4), .CNT_W(4), .THRESHOLD(2)) dut (
        .clk(clk), .nrst(nrst), .en(en), .start_bundling(start), .in_valid(in_valid),
        .bound_hv(hv), .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
        .sample_hv(sample_hv), .busy(busy)
    );

    bundler #(.DIM(8), .NUM_INPUTS(5), .CNT_W(2), .THRESHOLD(3)) dut_b (
        .clk(clk), .nrst(nrst), .en(en), .start_bundling(start_b), .in_valid(in_valid_b),
        .bound_hv(hv_b), .in_ready(in_ready_b), .out_ready(1'b1), .out_valid(out_valid_b),
        .sample_hv(sample_hv_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk)
        if (nrst && out_valid && out_ready) begin
            check("sb_pending", 32'(exp_q.size()), 1);
            if (exp_q.size() != 0) check("sb_sample_hv", sample_hv, exp_q.pop_front());
        end

    task automatic run_sample(input string tag, input logic [3:0][7:0] v, input logic [7:0] exp);
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_in_ready"}, in_ready, 1);
        for (int i = 3; i >= 0; i--) begin
            in_valid = 1;
            hv = v[i];
            @(negedge clk);
        end
        in_valid = 0;
        hv = '0;
        check({tag, "_thresh_no_valid"}, out_valid, 0);
        exp_q.push_back(exp);
        @(negedge clk);
        check({tag, "_latency_valid"}, out_valid, 1);
        @(negedge clk);
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        tbl[0] = '{v: {8'hFF, 8'h0F, 8'h03, 8'h00}, exp: 8'h0F};
        tbl[1] = '{v: {8'h00, 8'h00, 8'h00, 8'h00}, exp: 8'h00};
        tbl[2] = '{v: {8'hFF, 8'hFF, 8'h00, 8'h00}, exp: 8'hFF};
        tbl[3] = '{v: {8'h80, 8'h80, 8'h01, 8'h00}, exp: 8'h80};
        tbl[4] = '{v: {8'hF0, 8'h0F, 8'hF0, 8'h0F}, exp: 8'hFF};
        tbl[5] = '{v: {8'h01, 8'h02, 8'h04, 8'h08}, exp: 8'h00};
        tbl[6] = '{v: {8'hAA, 8'h55, 8'hAA, 8'h00}, exp: 8'hAA};

        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sample_hv", sample_hv, 0);
        @(negedge clk);
        nrst = 1;

        for (int t = 0; t < 7; t++) run_sample($sformatf("tbl%0d", t), tbl[t].v, tbl[t].exp);

        // gaps and en low mid-sample; blocked inputs would push bits to 1
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        in_valid = 1; hv = 8'hFF;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        in_valid = 1; hv = 8'h0F;
        @(negedge clk);
        en = 0; hv = 8'hFF;
        #1;
        check("en_low_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("en_low_busy", busy, 1);
        check("en_low_out_valid", out_valid, 0);
        en = 1; in_valid = 0;
        @(negedge clk);
        in_valid = 1; hv = 8'h03;
        @(negedge clk);
        hv = 8'h00;
        @(negedge clk);
        in_valid = 0;
        check("en_thresh_no_valid", out_valid, 0);
        exp_q.push_back(8'h0F);
        @(negedge clk);
        check("en_latency_valid", out_valid, 1);
        @(negedge clk);
        check("en_idle_busy", busy, 0);

        // hold in OUT with out_ready low; start/in_valid must be ignored
        out_ready = 0;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1;
            hv = (i < 2) ? 8'hFF : (i == 2) ? 8'h0F : 8'h00;
            @(negedge clk);
        end
        in_valid = 0;
        exp_q.push_back(8'hFF);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", out_valid, 1);
            check("hold_sample_hv", sample_hv, 8'hFF);
            check("hold_busy", busy, 1);
            start = 1; in_valid = 1; hv = 8'h00;
            @(negedge clk);
        end
        start = 0; in_valid = 0;
        check("hold_in_ready", in_ready, 0);
        @(posedge clk);
        #1 out_ready = 1;
        @(negedge clk);
        @(negedge clk);
        check("hold_after_valid", out_valid, 0);
        check("hold_after_busy", busy, 0);
        check("hold_retained_hv", sample_hv, 8'hFF);

        // reset after two accepts
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        in_valid = 1; hv = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        in_valid = 0;
        #2 nrst = 0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sample_hv", sample_hv, 0);
        @(negedge clk);
        nrst = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", out_valid, 0);
        end
        run_sample("post_rst", {8'h01, 8'h00, 8'h00, 8'h00}, 8'h00);
        run_sample("post_rst2", {8'hFF, 8'h0F, 8'h03, 8'h00}, 8'h0F);

        // saturating 2-bit counters, threshold 3, five inputs
        @(negedge clk);
        start_b = 1;
        @(negedge clk);
        start_b = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid_b = 1; hv_b = 8'hAA;
            @(negedge clk);
        end
        in_valid_b = 0;
        check("sat_thresh_no_valid", out_valid_b, 0);
        @(negedge clk);
        check("sat_out_valid", out_valid_b, 1);
        check("sat_sample_hv", sample_hv_b, 8'hAA);
        @(negedge clk);
        check("sat_idle_busy", busy_b, 0);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
